traffic_phase_ctrl: RTL and testbench

- Parametrised N-approach intersection controller. Replaces the fixed per-direction light blocks (south/east/west/north/pedestrian) and their ready handshake with a single round-robin phase sequencer.
- Drives green, yellow and red for NUM_DIR vehicle approaches plus one pedestrian crossing.
- Adds a latched pedestrian request, a per-direction enable mask and a blinking-yellow service mode.
- Sits between the button/decoder logic and the display/lamp drivers.

---
 rtl/traffic_phase_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - round-robin N-approach intersection phase sequencer
//
// Purpose: sequences ALL_RED -> GREEN -> YELLOW -> ALL_RED over the enabled
// approaches in round-robin order, inserts a pedestrian walk phase after an
// ALL_RED when a request is latched, and offers a blinking-yellow service mode.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   service_req   level; holds the controller in blinking-yellow service mode
//   ped_req       pedestrian button; latched into ped_pending
//   dir_en        per-approach enable, sampled when ALL_RED ends
//   verde/galben/rosu  green/yellow/red lamps per approach
//   verde_P/rosu_P     pedestrian walk/stop lamps
//   phase_idx     approach currently served
//   ped_pending   latched pedestrian request
//   phase_done    one-cycle pulse after a YELLOW phase ends
//   service       high while in service mode
module traffic_phase_ctrl #(
  parameter int NUM_DIR  = 4,
  parameter int CNT_W    = 8,
  parameter int TICK_DIV = 50000000,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int PED_T    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       service_req,
  input  logic                       ped_req,
  input  logic [NUM_DIR-1:0]         dir_en,
  output logic [NUM_DIR-1:0]         verde,
  output logic [NUM_DIR-1:0]         galben,
  output logic [NUM_DIR-1:0]         rosu,
  output logic                       verde_P,
  output logic                       rosu_P,
  output logic [$clog2(NUM_DIR)-1:0] phase_idx,
  output logic                       ped_pending,
  output logic                       phase_done,
  output logic                       service
);

  localparam int IDX_W = $clog2(NUM_DIR);
  localparam int PRE_W = $clog2(TICK_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_T - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIR - 1);

  typedef enum logic [2:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_PED_WALK,
    S_SERVICE
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] phase_idx_q, phase_idx_d;
  logic             ped_pending_q, ped_pending_d;
  logic             blink_q, blink_d;
  logic             phase_done_q, phase_done_d;

  logic             tick;
  logic             expire;
  logic [IDX_W-1:0] next_idx;
  logic             any_en;
  int               cand;

  assign tick   = (pre_q == PRE_LAST);
  assign expire = tick && (timer_q == '0);
  assign pre_d  = tick ? '0 : pre_q + 1'b1;

  // Next enabled approach after phase_idx. Scanning offsets from far to near
  // lets the nearest enabled candidate overwrite the others. Offset NUM_DIR
  // wraps back to the current approach when it is the only one enabled.
  always_comb begin
    next_idx = phase_idx_q;
    any_en   = 1'b0;
    cand     = 0;
    for (int k = NUM_DIR; k >= 1; k--) begin
      cand = (int'(phase_idx_q) + k) % NUM_DIR;
      if (dir_en[cand]) begin
        next_idx = IDX_W'(cand);
        any_en   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    phase_idx_d   = phase_idx_q;
    ped_pending_d = ped_pending_q;
    blink_d       = blink_q;
    phase_done_d  = 1'b0;

    if (service_req) begin
      // Service wins over any timer exit; the timer stays frozen meanwhile.
      state_d       = S_SERVICE;
      ped_pending_d = 1'b0;
      blink_d       = (state_q == S_SERVICE) ? (blink_q ^ tick) : 1'b0;
    end else if (state_q == S_SERVICE) begin
      // Restart from the top so approach 0 is considered first.
      state_d     = S_ALL_RED;
      timer_d     = ALLRED_LD;
      phase_idx_d = IDX_LAST;
      blink_d     = 1'b0;
    end else begin
      if (tick && (timer_q != '0)) begin
        timer_d = timer_q - 1'b1;
      end
      if (expire) begin
        case (state_q)
          S_ALL_RED: begin
            if (ped_pending_q) begin
              state_d       = S_PED_WALK;
              timer_d       = PED_LD;
              ped_pending_d = 1'b0;
            end else if (any_en) begin
              state_d     = S_GREEN;
              timer_d     = GREEN_LD;
              phase_idx_d = next_idx;
            end else begin
              timer_d = ALLRED_LD;
            end
          end
          S_GREEN: begin
            state_d = S_YELLOW;
            timer_d = YELLOW_LD;
          end
          S_YELLOW: begin
            state_d      = S_ALL_RED;
            timer_d      = ALLRED_LD;
            phase_done_d = 1'b1;
          end
          S_PED_WALK: begin
            state_d = S_ALL_RED;
            timer_d = ALLRED_LD;
          end
          default: ;
        endcase
      end
      // A press on the clearing edge re-latches the request.
      if (ped_req) begin
        ped_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_ALL_RED;
      pre_q         <= '0;
      timer_q       <= ALLRED_LD;
      phase_idx_q   <= IDX_LAST;
      ped_pending_q <= 1'b0;
      blink_q       <= 1'b0;
      phase_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      timer_q       <= timer_d;
      phase_idx_q   <= phase_idx_d;
      ped_pending_q <= ped_pending_d;
      blink_q       <= blink_d;
      phase_done_q  <= phase_done_d;
    end
  end

  logic [NUM_DIR-1:0] sel;
  assign sel = {{(NUM_DIR-1){1'b0}}, 1'b1} << phase_idx_q;

  always_comb begin
    verde   = '0;
    galben  = '0;
    rosu    = '1;
    verde_P = 1'b0;
    rosu_P  = 1'b1;
    service = 1'b0;
    case (state_q)
      S_GREEN: begin
        verde = sel;
        rosu  = ~sel;
      end
      S_YELLOW: begin
        galben = sel;
        rosu   = ~sel;
      end
      S_PED_WALK: begin
        verde_P = 1'b1;
        rosu_P  = 1'b0;
      end
      S_SERVICE: begin
        galben  = {NUM_DIR{blink_q}};
        rosu    = '0;
        rosu_P  = 1'b0;
        service = 1'b1;
      end
      default: ;
    endcase
  end

  assign phase_idx   = phase_idx_q;
  assign ped_pending = ped_pending_q;
  assign phase_done  = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

  localparam int ND  = 4;
  localparam int TD  = 4;
  localparam int GT  = 3;
  localparam int YT  = 1;
  localparam int AT  = 1;
  localparam int PT  = 2;

  localparam int M_AR  = 0;
  localparam int M_GR  = 1;
  localparam int M_YE  = 2;
  localparam int M_PED = 3;
  localparam int M_SVC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          service_req;
  logic          ped_req;
  logic [ND-1:0] dir_en;
  logic [ND-1:0] verde, galben, rosu;
  logic          verde_P, rosu_P;
  logic [1:0]    phase_idx;
  logic          ped_pending, phase_done, service;

  traffic_phase_ctrl #(
    .NUM_DIR(ND), .CNT_W(8), .TICK_DIV(TD), .GREEN_T(GT),
    .YELLOW_T(YT), .ALLRED_T(AT), .PED_T(PT)
  ) dut (
    .clk(clk), .rst(rst), .service_req(service_req), .ped_req(ped_req),
    .dir_en(dir_en), .verde(verde), .galben(galben), .rosu(rosu),
    .verde_P(verde_P), .rosu_P(rosu_P), .phase_idx(phase_idx),
    .ped_pending(ped_pending), .phase_done(phase_done), .service(service)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: phase name, ticks remaining, served approach,
  // latched request, blink level, done pulse and elapsed cycles.
  int m_mode, m_left, m_idx, m_ped, m_blink, m_done, m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_AR; m_left = AT; m_idx = ND - 1;
    m_ped = 0; m_blink = 0; m_done = 0; m_cyc = 0;
  endtask

  task automatic model_step(input logic svc, input logic pr, input logic [ND-1:0] en);
    bit tk;
    int newped;
    tk = (m_cyc % TD) == TD - 1;
    m_cyc++;
    m_done = 0;
    if (svc) begin
      m_blink = (m_mode == M_SVC) ? (m_blink ^ int'(tk)) : 0;
      m_mode  = M_SVC;
      m_ped   = 0;
    end else if (m_mode == M_SVC) begin
      m_mode = M_AR; m_left = AT; m_idx = ND - 1; m_blink = 0;
    end else begin
      newped = m_ped;
      if (tk) begin
        m_left--;
        if (m_left == 0) begin
          if (m_mode == M_AR) begin
            if (m_ped != 0) begin
              m_mode = M_PED; m_left = PT; newped = 0;
            end else begin
              m_left = AT;
              for (int k = 1; k <= ND; k++) begin
                if (en[(m_idx + k) % ND]) begin
                  m_idx = (m_idx + k) % ND; m_mode = M_GR; m_left = GT;
                  break;
                end
              end
            end
          end else if (m_mode == M_GR) begin
            m_mode = M_YE; m_left = YT;
          end else if (m_mode == M_YE) begin
            m_mode = M_AR; m_left = AT; m_done = 1;
          end else begin
            m_mode = M_AR; m_left = AT;
          end
        end
      end
      m_ped = pr ? 1 : newped;
    end
  endtask

  task automatic check_all(input string tag);
    logic [ND-1:0] ev, eg, er, one;
    logic evp, erp, esv;
    one = 4'b0001 << m_idx;
    ev = '0; eg = '0; er = '1; evp = 0; erp = 1; esv = 0;
    case (m_mode)
      M_GR:  begin ev = one; er = ~one; end
      M_YE:  begin eg = one; er = ~one; end
      M_PED: begin evp = 1; erp = 0; end
      M_SVC: begin eg = {ND{m_blink[0]}}; er = '0; erp = 0; esv = 1; end
      default: ;
    endcase
    chk({tag, ".verde"}, verde, ev);
    chk({tag, ".galben"}, galben, eg);
    chk({tag, ".rosu"}, rosu, er);
    chk({tag, ".verde_P"}, verde_P, evp);
    chk({tag, ".rosu_P"}, rosu_P, erp);
    chk({tag, ".phase_idx"}, phase_idx, m_idx);
    chk({tag, ".ped_pending"}, ped_pending, m_ped);
    chk({tag, ".phase_done"}, phase_done, m_done);
    chk({tag, ".service"}, service, esv);
  endtask

  // Inputs change at the falling edge; outputs are checked at the next one.
  task automatic step(input string tag, input logic svc, input logic pr, input logic [ND-1:0] en);
    service_req = svc; ped_req = pr; dir_en = en;
    @(posedge clk);
    if (rst) model_reset(); else model_step(svc, pr, en);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run_until(input string tag, input int mode, input int idx, input logic [ND-1:0] en);
    int n;
    n = 0;
    while (!(m_mode == mode && (idx < 0 || m_idx == idx)) && n < 200) begin
      step(tag, 1'b0, 1'b0, en);
      n++;
    end
    chk({tag, ".reached"}, (n < 200), 1);
  endtask

  initial begin
    int svc_left;
    logic [ND-1:0] ren;
    rst = 1'b1; service_req = 0; ped_req = 0; dir_en = 4'b1111;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.rosu_const", rosu, 4'b1111);
    rst = 1'b0;

    // Basic rotation with directed spot checks at tick boundaries.
    for (int i = 1; i <= 40; i++) begin
      step("rot", 1'b0, 1'b0, 4'b1111);
      if (i == 4)  begin chk("t1.verde", verde, 4'b0001); chk("t1.idx", phase_idx, 0); end
      if (i == 16) chk("t4.galben", galben, 4'b0001);
      if (i == 20) begin chk("t5.rosu", rosu, 4'b1111); chk("t5.done", phase_done, 1); end
      if (i == 24) chk("t6.verde", verde, 4'b0010);
    end

    // Masked approaches never go green.
    for (int i = 0; i < 80; i++) begin
      step("mask", 1'b0, 1'b0, 4'b1010);
      chk("mask.never02", verde & 4'b0101, 0);
    end

    // Pedestrian pulse during green of approach 1.
    run_until("ped_wait", M_GR, 1, 4'b1111);
    step("ped_pulse", 1'b0, 1'b1, 4'b1111);
    chk("ped.latched", ped_pending, 1);
    for (int i = 0; i < 60; i++) step("ped", 1'b0, 1'b0, 4'b1111);

    // Service mode entered mid-green, then released.
    run_until("svc_wait", M_GR, -1, 4'b1111);
    step("svc_in", 1'b1, 1'b0, 4'b1111);
    chk("svc.service", service, 1);
    chk("svc.verde", verde, 0);
    for (int i = 0; i < 20; i++) step("svc", 1'b1, 1'b0, 4'b1111);
    for (int i = 0; i < 20; i++) step("svc_out", 1'b0, 1'b0, 4'b1111);

    // No approach enabled, then a single one restored.
    for (int i = 0; i < 40; i++) begin
      step("dis", 1'b0, 1'b0, 4'b0000);
      if (i > 30) chk("dis.done", phase_done, 0);
    end
    for (int i = 0; i < 30; i++) step("one", 1'b0, 1'b0, 4'b0100);

    // Randomised traffic.
    svc_left = 0;
    ren = 4'b1111;
    for (int i = 0; i < 2500; i++) begin
      if (svc_left == 0 && $urandom_range(0, 199) == 0) svc_left = $urandom_range(1, 24);
      if ($urandom_range(0, 49) == 0) ren = 4'($urandom_range(0, 15));
      step("rand", svc_left != 0, $urandom_range(0, 29) == 0, ren);
      if (svc_left != 0) svc_left--;
    end

    // Asynchronous reset in the middle of a yellow phase.
    run_until("ry_wait", M_YE, -1, 4'b1111);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.verde", verde, 0);
    chk("arst.galben", galben, 0);
    chk("arst.rosu", rosu, 4'b1111);
    chk("arst.rosu_P", rosu_P, 1);
    chk("arst.verde_P", verde_P, 0);
    chk("arst.idx", phase_idx, 3);
    chk("arst.done", phase_done, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step("restart", 1'b0, 1'b0, 4'b1111);
      if (i == 4) chk("restart.verde", verde, 4'b0001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
